// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter for the single audio channel: latches game-event
// request pulses, grants the highest-index requester and times it in 8 kHz ticks.
module sound_arbiter #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 16,
  parameter int SEL_W = $clog2(N_REQ + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_8khz,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] req_dur,
  input  logic                   mute,
  output logic [SEL_W-1:0]       sound_sel,
  output logic                   playing,
  output logic [N_REQ-1:0]       grant,
  output logic                   done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] pending;
  logic [DUR_W-1:0] cnt;
  logic [IDX_W-1:0] cur;

  logic [N_REQ-1:0] eff;
  logic [IDX_W-1:0] win;
  logic             any_eff;
  logic             preempt;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] cur_onehot;
  logic [DUR_W-1:0] win_dur;
  logic [DUR_W-1:0] cur_dur;
  logic [DUR_W-1:0] win_load;
  logic [DUR_W-1:0] cur_load;
  logic             in_play;
  logic             retrig;
  logic             finish;
  logic             start_win;
  logic             stop_play;

  // Arbitration view of this cycle: sticky pending plus fresh pulses, with the
  // winner being the highest set index and preemption meaning anything above cur.
  always_comb begin
    eff     = mute ? '0 : (pending | req);
    any_eff = |eff;
    win     = '0;
    preempt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (eff[i]) begin
        win = IDX_W'(i);
        if (IDX_W'(i) > cur) preempt = 1'b1;
      end
    end
    win_onehot = N_REQ'(1) << win;
    cur_onehot = N_REQ'(1) << cur;
    win_dur    = req_dur[win*DUR_W +: DUR_W];
    cur_dur    = req_dur[cur*DUR_W +: DUR_W];
    win_load   = (win_dur == '0) ? DUR_W'(1) : win_dur;
    cur_load   = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
  end

  // Per-cycle action, resolved in the order mute, preempt, retrigger, tick.
  always_comb begin
    in_play   = (state == PLAY);
    retrig    = in_play && !mute && !preempt && req[cur];
    finish    = in_play && !mute && !preempt && !req[cur] &&
                tick_8khz && (cnt <= DUR_W'(1));
    start_win = (!in_play && any_eff) ||
                (in_play && !mute && preempt) ||
                (finish && any_eff);
    stop_play = (in_play && mute) || (finish && !any_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      cnt       <= '0;
      cur       <= '0;
      sound_sel <= '0;
      playing   <= 1'b0;
      grant     <= '0;
      done      <= 1'b0;
    end else begin
      grant <= '0;
      done  <= finish;
      if (start_win) begin
        state     <= PLAY;
        cur       <= win;
        sound_sel <= SEL_W'(win) + SEL_W'(1);
        playing   <= 1'b1;
        grant     <= win_onehot;
        cnt       <= win_load;
        pending   <= eff & ~win_onehot;
      end else if (stop_play) begin
        state     <= IDLE;
        sound_sel <= '0;
        playing   <= 1'b0;
        cnt       <= '0;
        pending   <= '0;
      end else begin
        // A load beats a coincident tick; lower-priority requests just accumulate.
        if (retrig) begin
          cnt   <= cur_load;
          grant <= cur_onehot;
        end else if (in_play && tick_8khz) begin
          cnt <= cnt - DUR_W'(1);
        end
        pending <= eff & ~cur_onehot;
      end
    end
  end

endmodule
